// File: rtl/sorcerer_ps2_rx_if.sv
// PS/2 receiver bus: raw PS/2 pins in, Sorcerer key-event interface out.
// slave  = the receiver (consumes pins, produces key events)
// master = the environment (drives pins, consumes key events)
interface sorcerer_ps2_rx_if;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic       KEY_STROBE;
  logic       KEY_PRESSED;
  logic       KEY_EXTENDED;
  logic [7:0] KEY_CODE;
  logic       RX_ERROR;

  modport slave (
    input  PS2_CLK, PS2_DATA,
    output KEY_STROBE, KEY_PRESSED, KEY_EXTENDED, KEY_CODE, RX_ERROR
  );

  modport master (
    output PS2_CLK, PS2_DATA,
    input  KEY_STROBE, KEY_PRESSED, KEY_EXTENDED, KEY_CODE, RX_ERROR
  );
endinterface

// File: rtl/sorcerer_ps2_rx.sv
// PS/2 keyboard receiver for the Sorcerer keyboard matrix, clocked by CLK12.
// Synchronises and glitch-filters the PS/2 lines, deserialises 11-bit frames,
// decodes E0/F0 prefixes, swallows the E1 Pause sequence and aborts stalled
// frames after TIMEOUT cycles.
// Optional build macro PS2_TYPEMATIC_FILTER_EN suppresses typematic repeats.
//
// state  | meaning
// IDLE   | waiting for a start bit (falling edge with data low)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | waiting for the stop bit; frame is evaluated on its falling edge
module sorcerer_ps2_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 12000
) (
  input  logic             CLK12,
  input  logic             RESET,
  sorcerer_ps2_rx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [3:0]      FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [TW-1:0]   TMO_MAX   = TW'(TIMEOUT);

  state_t        state, next_state;
  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          filt_clk, filt_prev;
  logic [3:0]    filt_cnt;
  logic          fe;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          shift_en, par_en, done, tmo_hit;
  logic          ext, rel;
  logic [2:0]    skip_cnt;
  logic          frame_ok, key_evt, suppress;
  logic          key_strobe, key_pressed, key_extended, rx_error;
  logic [7:0]    key_code;

  // Two-flop synchronisers; reset to the idle-high line level.
  always_ff @(posedge CLK12) begin
    if (RESET) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= bus.PS2_CLK;
      clk_s2  <= clk_s1;
      data_s1 <= bus.PS2_DATA;
      data_s2 <= data_s1;
    end
  end

  // Filtered clock moves only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge CLK12) begin
    if (RESET) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

  assign fe = filt_prev & ~filt_clk;

  // FSM state register.
  always_ff @(posedge CLK12) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // FSM next state and per-cycle datapath strobes; timeout wins over fe.
  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    done       = 1'b0;
    tmo_hit    = (state != IDLE) && (tmo_cnt == TMO_MAX);
    if (tmo_hit) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:   if (fe && !data_s2) next_state = DATA;
        DATA:   if (fe) begin
                  shift_en = 1'b1;
                  if (bit_cnt == 3'd7) next_state = PARITY;
                end
        PARITY: if (fe) begin
                  par_en     = 1'b1;
                  next_state = STOP;
                end
        STOP:   if (fe) begin
                  done       = 1'b1;
                  next_state = IDLE;
                end
        default: next_state = IDLE;
      endcase
    end
  end

  // Shift register, bit counter and parity capture.
  always_ff @(posedge CLK12) begin
    if (RESET) begin
      bit_cnt <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (state == IDLE) bit_cnt <= '0;
      if (shift_en) begin
        shift   <= {data_s2, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (par_en) par_bit <= data_s2;
    end
  end

  // Mid-frame inactivity counter, restarted by every falling edge.
  always_ff @(posedge CLK12) begin
    if (RESET || state == IDLE || fe) tmo_cnt <= '0;
    else if (tmo_cnt != TMO_MAX)      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Stop bit is the synced data in the stop fe cycle.
  assign frame_ok = (^{shift, par_bit}) & data_s2;
  assign key_evt  = done && frame_ok && (skip_cnt == 3'd0) &&
                    (shift != 8'hE0) && (shift != 8'hE1) && (shift != 8'hF0);

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       last_valid;
  logic [8:0] last_make;

  assign suppress = ~rel & last_valid & (last_make == {ext, shift});

  // Remember the last make so auto-repeats of the held key are dropped.
  always_ff @(posedge CLK12) begin
    if (RESET) begin
      last_valid <= 1'b0;
      last_make  <= '0;
    end else if (key_evt) begin
      if (rel) begin
        last_valid <= 1'b0;
      end else if (!suppress) begin
        last_make  <= {ext, shift};
        last_valid <= 1'b1;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // Frame evaluation: errors, prefix tracking, Pause skipping, key events.
  always_ff @(posedge CLK12) begin
    if (RESET) begin
      ext          <= 1'b0;
      rel          <= 1'b0;
      skip_cnt     <= '0;
      key_strobe   <= 1'b0;
      key_pressed  <= 1'b0;
      key_extended <= 1'b0;
      key_code     <= '0;
      rx_error     <= 1'b0;
    end else begin
      key_strobe <= 1'b0;
      rx_error   <= tmo_hit;
      if (done) begin
        if (!frame_ok) begin
          rx_error <= 1'b1;
          ext      <= 1'b0;
          rel      <= 1'b0;
          skip_cnt <= '0;
        end else if (skip_cnt != 3'd0) begin
          skip_cnt <= skip_cnt - 3'd1;
        end else if (shift == 8'hE1) begin
          skip_cnt <= 3'd7;
        end else if (shift == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift == 8'hF0) begin
          rel <= 1'b1;
        end else begin
          ext <= 1'b0;
          rel <= 1'b0;
          if (!suppress) begin
            key_strobe   <= 1'b1;
            key_code     <= shift;
            key_extended <= ext;
            key_pressed  <= ~rel;
          end
        end
      end
    end
  end

  assign bus.KEY_STROBE   = key_strobe;
  assign bus.KEY_PRESSED  = key_pressed;
  assign bus.KEY_EXTENDED = key_extended;
  assign bus.KEY_CODE     = key_code;
  assign bus.RX_ERROR     = rx_error;
endmodule
